// File: rtl/pipe_adder_cascade_pkg.sv
// Shared parameters and helpers for the pipelined adder/subtractor cascade.
// Stage count derivation and parameter sanity check used at elaboration.
package pipe_adder_cascade_pkg;

    function automatic bit params_ok(input int bits, input int stage_bits);
        return (stage_bits >= 1) && (bits >= stage_bits) && ((bits % stage_bits) == 0);
    endfunction

    // Falls back to one stage for illegal parameters so elaboration can reach the check.
    function automatic int calc_stages(input int bits, input int stage_bits);
        return ((stage_bits >= 1) && (bits >= stage_bits)) ? (bits / stage_bits) : 1;
    endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational WIDTH-bit ripple chain of full adders; also exposes the carry
// into its MSB so the top segment can derive signed overflow.
module adder_segment #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [WIDTH:0] c;

    assign c[0] = cin;

    genvar gi;
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
        full_adder u_fa (
            .a  (a[gi]),
            .b  (b[gi]),
            .ci (c[gi]),
            .s  (sum[gi]),
            .co (c[gi+1])
        );
    end

    assign cout  = c[WIDTH];
    assign c_msb = c[WIDTH-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell, the building block of every ripple segment.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipe_adder_cascade.sv
// Pipelined carry-chain adder/subtractor: one STAGE_BITS segment per stage,
// operand chunks skewed in, result chunks deskewed out, global-stall handshake.
module pipe_adder_cascade
    import pipe_adder_cascade_pkg::*;
#(
    parameter int BITS       = 32,
    parameter int STAGE_BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            carry_in,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS:0]   out,
    output logic            overflow
);

    localparam int STAGES = calc_stages(BITS, STAGE_BITS);
    localparam int SB     = STAGE_BITS;

    if (!params_ok(BITS, STAGE_BITS)) begin : g_param_check
        $error("pipe_adder_cascade: BITS must be a positive multiple of STAGE_BITS");
    end

    logic              advance;
    logic [BITS-1:0]   b_eff;
    logic              cin_eff;
    logic [STAGES-1:0] valid_reg;
    logic [STAGES-1:0] carry_reg;
    logic              overflow_reg;
    logic [BITS-1:0]   out_sum;

    logic [SB-1:0]     seg_a   [STAGES];
    logic [SB-1:0]     seg_b   [STAGES];
    logic [SB-1:0]     seg_sum [STAGES];
    logic [STAGES-1:0] seg_cin;
    logic [STAGES-1:0] seg_cout;
    logic              seg_cmsb [STAGES];

    // Subtraction is folded in at capture; later stages never see the mode.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : carry_in;

    assign advance   = !valid_reg[STAGES-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = valid_reg[STAGES-1];
    assign out       = {carry_reg[STAGES-1], out_sum};
    assign overflow  = overflow_reg;

    genvar gi;
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign seg_a[gi]   = a[SB-1:0];
            assign seg_b[gi]   = b_eff[SB-1:0];
            assign seg_cin[gi] = cin_eff;
        end else begin : g_skew
            // Chunk gi waits gi cycles so it meets the carry of its own beat.
            logic [SB-1:0] a_skew_reg [gi];
            logic [SB-1:0] b_skew_reg [gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < gi; i++) begin
                        a_skew_reg[i] <= '0;
                        b_skew_reg[i] <= '0;
                    end
                end else if (advance) begin
                    a_skew_reg[0] <= a[gi*SB +: SB];
                    b_skew_reg[0] <= b_eff[gi*SB +: SB];
                    for (int i = 1; i < gi; i++) begin
                        a_skew_reg[i] <= a_skew_reg[i-1];
                        b_skew_reg[i] <= b_skew_reg[i-1];
                    end
                end
            end

            assign seg_a[gi]   = a_skew_reg[gi-1];
            assign seg_b[gi]   = b_skew_reg[gi-1];
            assign seg_cin[gi] = carry_reg[gi-1];
        end

        adder_segment #(
            .WIDTH (SB)
        ) u_segment (
            .a     (seg_a[gi]),
            .b     (seg_b[gi]),
            .cin   (seg_cin[gi]),
            .sum   (seg_sum[gi]),
            .cout  (seg_cout[gi]),
            .c_msb (seg_cmsb[gi])
        );

        // Resolved chunk is held back until the top chunk of the same beat lands.
        logic [SB-1:0] sum_dly_reg [STAGES-gi];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < STAGES - gi; i++) begin
                    sum_dly_reg[i] <= '0;
                end
            end else if (advance) begin
                sum_dly_reg[0] <= seg_sum[gi];
                for (int i = 1; i < STAGES - gi; i++) begin
                    sum_dly_reg[i] <= sum_dly_reg[i-1];
                end
            end
        end

        assign out_sum[gi*SB +: SB] = sum_dly_reg[STAGES-gi-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg    <= '0;
            carry_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (advance) begin
            valid_reg    <= (valid_reg << 1) | STAGES'(in_valid);
            carry_reg    <= seg_cout;
            overflow_reg <= seg_cout[STAGES-1] ^ seg_cmsb[STAGES-1];
        end
    end

endmodule
